// File: rtl/sha3_msg_sequencer.sv
// sha3_msg_sequencer: streams message words into the SHA-3 core, inserts the terminating pad word, serialises the digest
module sha3_msg_sequencer #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic [1:0]       s_bytes,
    output logic             s_ready,
    output logic [31:0]      core_in,
    output logic             core_in_ready,
    output logic             core_is_last,
    output logic [1:0]       core_byte_num,
    output logic             core_reset,
    input  logic             core_buffer_full,
    input  logic [511:0]     core_out,
    input  logic             core_out_ready,
    output logic [31:0]      d_data,
    output logic             d_valid,
    output logic             d_last,
    input  logic             d_ready,
    output logic             busy,
    output logic [LEN_W-1:0] msg_len
);
    typedef enum logic [2:0] {CLR, FEED, PAD, WAIT, DRAIN} state_t;
    state_t r_state, w_next;
    logic [511:0] r_digest;
    logic [3:0] r_idx;
    logic [LEN_W-1:0] r_len;
    logic r_started;
    logic w_acc, w_pad;
    logic [2:0] w_inc;
    logic [LEN_W:0] w_sum;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= CLR;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        s_ready = 1'b0;
        w_acc = 1'b0;
        w_pad = 1'b0;
        case (r_state)
            CLR: w_next = FEED;
            FEED: begin
                s_ready = !core_buffer_full;
                w_acc = s_valid && !core_buffer_full;
                if (w_acc && s_last) w_next = (s_bytes != 2'd0) ? WAIT : PAD;
            end
            PAD: begin
                w_pad = !core_buffer_full;
                if (w_pad) w_next = WAIT;
            end
            WAIT: if (core_out_ready) w_next = DRAIN;
            DRAIN: if (d_ready && r_idx == 4'd15) w_next = CLR;
            default: w_next = CLR;
        endcase
    end
    assign core_in_ready = w_acc || w_pad;
    assign core_in = w_acc ? s_data : 32'd0;
    assign core_is_last = w_pad || (w_acc && s_last && s_bytes != 2'd0);
    assign core_byte_num = (w_acc && s_last) ? s_bytes : 2'd0;
    assign core_reset = !reset_n || r_state == CLR;
    assign busy = reset_n && !(r_state == FEED && !r_started);
    assign d_valid = r_state == DRAIN;
    assign d_data = d_valid ? r_digest[511:480] : 32'd0;
    assign d_last = d_valid && r_idx == 4'd15;
    assign msg_len = r_len;
    // first word of a message restarts the count instead of accumulating
    assign w_inc = (s_last && s_bytes != 2'd0) ? {1'b0, s_bytes} : 3'd4;
    assign w_sum = {1'b0, r_started ? r_len : {LEN_W{1'b0}}} + (LEN_W+1)'(w_inc);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digest <= '0;
            r_idx <= 4'd0;
            r_len <= '0;
            r_started <= 1'b0;
        end else begin
            if (r_state == CLR) r_started <= 1'b0;
            if (w_acc) begin
                r_len <= w_sum[LEN_W] ? {LEN_W{1'b1}} : w_sum[LEN_W-1:0];
                r_started <= 1'b1;
            end
            if (r_state == WAIT && core_out_ready) begin
                r_digest <= core_out;
                r_idx <= 4'd0;
            end
            if (r_state == DRAIN && d_ready) begin
                r_digest <= r_digest << 32;
                r_idx <= r_idx + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_sha3_msg_sequencer.sv
// tb_sha3_msg_sequencer: directed bench with a simple core model returning a fixed digest
module tb_sha3_msg_sequencer;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [31:0] s_data = '0;
    logic s_valid = 1'b0, s_last = 1'b0;
    logic [1:0] s_bytes = '0;
    logic s_ready, core_in_ready, core_is_last, core_reset;
    logic [31:0] core_in, d_data;
    logic [1:0] core_byte_num;
    logic core_buffer_full = 1'b0;
    logic [511:0] core_out;
    logic core_out_ready = 1'b0;
    logic d_valid, d_last, busy;
    logic d_ready = 1'b0;
    logic [31:0] msg_len;
    int n_tests = 0, n_fail = 0;
    int cnt = 0;
    logic [34:0] wq[$];

    sha3_msg_sequencer #(.LEN_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_bytes(s_bytes), .s_ready(s_ready), .core_in(core_in), .core_in_ready(core_in_ready),
        .core_is_last(core_is_last), .core_byte_num(core_byte_num), .core_reset(core_reset),
        .core_buffer_full(core_buffer_full), .core_out(core_out), .core_out_ready(core_out_ready),
        .d_data(d_data), .d_valid(d_valid), .d_last(d_last), .d_ready(d_ready), .busy(busy),
        .msg_len(msg_len)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 64; i++) core_out[511-8*i -: 8] = 8'(i);

    // core model: digest ready 10 cycles after the is_last write, cleared by core_reset
    always @(posedge clk) begin
        if (core_reset) begin
            cnt <= 0;
            core_out_ready <= 1'b0;
        end else begin
            if (core_in_ready) wq.push_back({core_in, core_is_last, core_byte_num});
            if (core_in_ready && core_is_last) cnt <= 1;
            else if (cnt != 0 && cnt < 10) cnt <= cnt + 1;
            core_out_ready <= (cnt == 10);
        end
    end

    always @(posedge clk) begin
        n_tests++;
        assert (!(core_in_ready && core_buffer_full)) else begin
            n_fail++;
            $error("FAIL in_ready_while_full observed=1 expected=0");
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv();
        for (int i = 0; i < 40 && !d_valid; i++) @(negedge clk);
        chk("dv_timeout", d_valid, 1);
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] b,
                        input logic el, input logic [1:0] eb);
        s_valid = 1'b1; s_data = d; s_last = l; s_bytes = b;
        #1;
        chk("in_ready", core_in_ready, 1);
        chk("core_in", core_in, d);
        chk("is_last", core_is_last, el);
        chk("byte_num", core_byte_num, eb);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic drain(input bit tog);
        int k = 0, cyc = 0;
        bit ph = 1'b0;
        while (k < 16) begin
            if (tog && ph) begin
                d_ready = 1'b0; ph = 1'b0;
            end else begin
                d_ready = 1'b1; ph = 1'b1;
                #1;
                chk("d_valid", d_valid, 1);
                chk($sformatf("d_data%0d", k), d_data, core_out[511-32*k -: 32]);
                chk($sformatf("d_last%0d", k), d_last, k == 15);
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        d_ready = 1'b0;
        if (tog) chk("drain_cycles", cyc, 31);
        chk("clr_core_reset", core_reset, 1);
        chk("clr_d_valid", d_valid, 0);
        chk("clr_s_ready", s_ready, 0);
        @(negedge clk);
        chk("feed_core_reset", core_reset, 0);
        chk("feed_s_ready", s_ready, 1);
    endtask

    initial begin
        #1;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_msg_len", msg_len, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_in_ready", core_in_ready, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_core_reset", core_reset, 1);
        chk("post_rst_s_ready", s_ready, 0);
        @(negedge clk);
        chk("feed_core_reset", core_reset, 0);
        chk("feed_s_ready", s_ready, 1);
        chk("feed_idle_busy", busy, 0);

        // 3-byte message
        send(32'h61626300, 1'b1, 2'd3, 1'b1, 2'd3);
        chk("m1_msg_len", msg_len, 3);
        chk("m1_s_ready", s_ready, 0);
        chk("m1_busy", busy, 1);
        wait_dv();
        drain(1'b0);

        // 8-byte message ending on a word boundary needs a pad write
        send(32'h41424344, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("m2_busy_mid", busy, 1);
        send(32'h45464748, 1'b1, 2'd0, 1'b0, 2'd0);
        #1;
        chk("pad_s_ready", s_ready, 0);
        chk("pad_in_ready", core_in_ready, 1);
        chk("pad_core_in", core_in, 0);
        chk("pad_is_last", core_is_last, 1);
        chk("pad_byte_num", core_byte_num, 0);
        @(negedge clk);
        chk("m2_msg_len", msg_len, 8);
        chk("m2_wait_in_ready", core_in_ready, 0);
        wait_dv();
        drain(1'b0);

        // 5-word message with backpressure on data and on the pad word
        wq.delete();
        send(32'h10000000, 1'b0, 2'd0, 1'b0, 2'd0);
        s_valid = 1'b1; s_data = 32'h10000001;
        repeat (5) begin
            core_buffer_full = 1'b1;
            #1;
            chk("bf_s_ready", s_ready, 0);
            chk("bf_in_ready", core_in_ready, 0);
            @(negedge clk);
        end
        core_buffer_full = 1'b0;
        for (int i = 1; i < 5; i++) send(32'h10000000 + 32'(i), i == 4, 2'd0, 1'b0, 2'd0);
        repeat (3) begin
            core_buffer_full = 1'b1;
            #1;
            chk("padbf_in_ready", core_in_ready, 0);
            @(negedge clk);
        end
        core_buffer_full = 1'b0;
        #1;
        chk("padbf_in_ready4", core_in_ready, 1);
        chk("padbf_is_last", core_is_last, 1);
        chk("padbf_core_in", core_in, 0);
        @(negedge clk);
        chk("m3_msg_len", msg_len, 20);
        chk("m3_writes", wq.size(), 6);
        for (int i = 0; i < 5 && i < wq.size(); i++)
            chk($sformatf("m3_w%0d", i), wq[i], {32'h10000000 + 32'(i), 1'b0, 2'd0});
        if (wq.size() > 5) chk("m3_pad", wq[5], {32'h0, 1'b1, 2'd0});
        wait_dv();
        drain(1'b1);

        // reset in the middle of a drain
        send(32'h58590000, 1'b1, 2'd2, 1'b1, 2'd2);
        chk("m4_msg_len", msg_len, 2);
        wait_dv();
        d_ready = 1'b1;
        repeat (7) @(negedge clk);
        d_ready = 1'b0;
        chk("m4_mid_d_data", d_data, core_out[511-32*7 -: 32]);
        reset_n = 1'b0;
        #1;
        chk("mr_d_valid", d_valid, 0);
        chk("mr_msg_len", msg_len, 0);
        chk("mr_core_reset", core_reset, 1);
        chk("mr_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mr_post_core_reset", core_reset, 1);
        @(negedge clk);
        chk("mr_feed_core_reset", core_reset, 0);
        chk("mr_feed_s_ready", s_ready, 1);
        send(32'h5a000000, 1'b1, 2'd1, 1'b1, 2'd1);
        chk("m5_msg_len", msg_len, 1);
        wait_dv();
        drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sha3_msg_sequencer.md
# sha3_msg_sequencer

Front-end controller for the `sha3_low_throughput` core. It accepts a message as a stream of 32-bit words from one requester and drives the core's input handshake. It inserts the zero-byte terminating word the core requires when a message ends on a word boundary. It captures the 512-bit digest and returns it as 16 serial 32-bit words, then clears the core for the next message.

## Interface
Parameters:
- LEN_W, 32, width of the message byte counter `msg_len`

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- s_data  in  32  message word; byte 0 in [31:24]
- s_valid  in  1  requester word valid
- s_last  in  1  word is the final word of the message
- s_bytes  in  2  valid bytes in the final word; 0 means 4; ignored unless s_last
- s_ready  out  1  sequencer accepts word this cycle
- core_in  out  32  to core `in`
- core_in_ready  out  1  to core `in_ready`
- core_is_last  out  1  to core `is_last`
- core_byte_num  out  2  to core `byte_num`
- core_reset  out  1  to core `reset` (active high)
- core_buffer_full  in  1  from core `buffer_full`
- core_out  in  512  from core `out`
- core_out_ready  in  1  from core `out_ready`
- d_data  out  32  digest word
- d_valid  out  1  digest word valid
- d_last  out  1  digest word 15
- d_ready  in  1  consumer accepts digest word
- busy  out  1  high in every state except FEED-with-no-word-accepted-yet
- msg_len  out  LEN_W  bytes accepted for current/last message

## Operation
- FSM states: CLR, FEED, PAD, WAIT, DRAIN.
- Reset (reset_n low), asynchronous:
  - state=CLR; core_reset=1 (combinational `~reset_n | state==CLR`).
  - All other outputs 0, including d_*, s_ready, core_in*, busy and msg_len.
- CLR: core_reset=1 for exactly one cycle, then FEED.
- FEED:
  - s_ready = !core_buffer_full.
  - On s_valid&&s_ready: core_in=s_data and core_in_ready=1 combinationally, in the same cycle.
    - Not s_last: core_is_last=0; msg_len += 4.
    - s_last with s_bytes≠0: core_is_last=1, core_byte_num=s_bytes; msg_len += s_bytes; go to WAIT.
    - s_last with s_bytes=0: core_is_last=0; msg_len += 4; go to PAD.
  - First accepted word of a message loads msg_len with its count instead of adding.
  - msg_len saturates at all-ones.
- PAD:
  - s_ready=0.
  - When !core_buffer_full: core_in=0, core_in_ready=1, core_is_last=1, core_byte_num=0 for one cycle; go to WAIT.
  - Otherwise hold.
- WAIT:
  - s_ready=0.
  - When core_out_ready=1: register core_out into a 512-bit digest register, clear word index, go to DRAIN.
- DRAIN:
  - d_valid=1, d_data=digest[511-32*idx -: 32], d_last=(idx==15).
  - On d_ready: idx++.
  - On d_ready with idx==15: go to CLR.
- core_in_ready is never asserted while core_buffer_full=1.
- core_byte_num=0 and core_is_last=0 whenever core_in_ready=0; core_in=0 likewise.
- Empty (0-byte) messages are not supported: every message carries at least one word.
- s_valid outside FEED is ignored (s_ready=0). The requester holds s_data stable until accepted.
- Reset mid-message or mid-drain discards everything: partial message, digest and index. The core is cleared via core_reset.

## Timing
- Input path latency 0: accepted word appears on core_in in the same cycle.
- core_out_ready sampled high at cycle M: d_valid=1 from M+1.
- Final d_ready handshake at cycle N: core_reset=1 in N+1; s_ready may be 1 in N+2.
- After reset_n rises: core_reset=1 for one cycle; FEED (s_ready possible) on the following cycle.
- Minimum per-message overhead beyond data words:
  - 1 PAD cycle, only when the message length is a multiple of 4.
  - Core latency.
  - 16 drain cycles.
  - 1 CLR cycle.
- Simultaneous core_buffer_full rise and s_valid: no transfer. core_buffer_full is sampled combinationally in the same cycle.

## Test plan
All scenarios use a bench core model. Its out = 512'h000102…3f, asserted 10 cycles after the is_last word.

- 3-byte message s_data=32'h61626300, s_last=1, s_bytes=3 -> same cycle: core_in=32'h61626300, core_in_ready=1, core_is_last=1, core_byte_num=3; then msg_len=3, first d_data=32'h00010203, 16th d_data=32'h3c3d3e3f with d_last=1.
- 8-byte message (two words, s_bytes=0 on last) -> two core writes with is_last=0, then one PAD write core_in=0, is_last=1, byte_num=0; msg_len=8.
- core_buffer_full held high 5 cycles after word 1 of a 5-word message -> s_ready=0 and no core_in_ready for those 5 cycles; all 5 words reach the core in order, none dropped or duplicated.
- d_ready toggled 1/0 each cycle during DRAIN -> 16 words in order over 31 cycles, d_last only on word 15, then core_reset=1 for exactly one cycle, then s_ready=1.
- core_buffer_full=1 on entry to PAD for 3 cycles -> pad write issued on the 4th cycle only.
- reset_n pulsed low during DRAIN at idx=7 -> d_valid=0 and msg_len=0 immediately; core_reset=1 during reset and one cycle after; next message's digest starts from word 0.
